// File: rtl/whack_pkg.sv
// Shared constants and types for the whack-a-mole player-input path.
// DEBOUNCE_CNT is the 100 MHz value; simulation overrides it with DEBOUNCE_CNT_SIM.
package whack_pkg;

    localparam int N_BTN            = 4;
    localparam int IDX_W            = 2;
    localparam int DEBOUNCE_CNT     = 500000;
    localparam int DEBOUNCE_CNT_SIM = 4;
    localparam int CNT_W            = 19;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/hit_if.sv
// Valid/ready hit channel from the button reader to the game FSM.
interface hit_if #(
    parameter int IDX_W = whack_pkg::IDX_W
) ();

    logic             hit_valid;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_ready;

    modport master (output hit_valid, output hit_idx, input hit_ready);
    modport slave  (input hit_valid, input hit_idx, output hit_ready);

endinterface

// File: rtl/debounce_bit.sv
// One button: 2-FF synchroniser, stability counter and debounced level.
// rise_o flags the cycle whose edge will raise the level, so the top can register it.
module debounce_bit #(
    parameter int DEBOUNCE_CNT = whack_pkg::DEBOUNCE_CNT,
    parameter int CNT_W        = whack_pkg::CNT_W
) (
    input  logic master_clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments in clocked blocks keep the synchroniser stages from collapsing into one.
    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/button_reader.sv
// Debounced mole buttons, press pulses and a 1-entry hit buffer for the game FSM.
// Lowest-index press wins; dropped presses pulse overrun.
module button_reader #(
    parameter int N_BTN        = whack_pkg::N_BTN,
    parameter int IDX_W        = whack_pkg::IDX_W,
    parameter int DEBOUNCE_CNT = whack_pkg::DEBOUNCE_CNT,
    parameter int CNT_W        = whack_pkg::CNT_W
) (
    input  logic             master_clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             overrun,
    hit_if.master            hit
);

    import whack_pkg::*;

    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] press_q;
    buf_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovr_q, ovr_d;
    logic [IDX_W-1:0] lo_idx;
    logic             any_press, multi_press, pop;

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CNT(DEBOUNCE_CNT),
            .CNT_W       (CNT_W)
        ) u_db (
            .master_clk(master_clk),
            .rst       (rst),
            .btn_raw_i (btn_raw[i]),
            .level_o   (btn_level[i]),
            .rise_o    (rise[i])
        );
    end

    always_comb begin
        lo_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_q[i]) lo_idx = IDX_W'(i);
        end
    end

    assign any_press   = |press_q;
    assign multi_press = (press_q & (press_q - N_BTN'(1))) != '0;
    assign pop         = (state_q == BUF_FULL) && hit.hit_ready;

    // Extra simultaneous presses are always dropped, even when the buffer accepts one.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = multi_press;
        case (state_q)
            BUF_EMPTY: begin
                if (any_press) begin
                    state_d = BUF_FULL;
                    idx_d   = lo_idx;
                end
            end
            BUF_FULL: begin
                if (any_press) begin
                    if (pop) idx_d = lo_idx;
                    else     ovr_d = 1'b1;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            press_q <= '0;
            state_q <= BUF_EMPTY;
            idx_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            press_q <= rise;
            state_q <= state_d;
            idx_q   <= idx_d;
            ovr_q   <= ovr_d;
        end
    end

    assign btn_press     = press_q;
    assign overrun       = ovr_q;
    assign hit.hit_valid = (state_q == BUF_FULL);
    assign hit.hit_idx   = idx_q;

endmodule
